// File: rtl/mem_pkg.sv
// Shared types, default geometry and the byte-to-bit mask helper used by the
// timed line memory and its line RAM.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int DEF_LINE_BITS = 256;
    localparam int DEF_DEPTH     = 512;
    localparam int DEF_LATENCY   = 10;

    // Widest line the mask helper covers; narrower lines truncate its result.
    localparam int MAX_LINE_BYTES = 128;
    localparam int MAX_LINE_BITS  = MAX_LINE_BYTES * 8;

    function automatic logic [MAX_LINE_BITS-1:0] expand_mask(
        input logic [MAX_LINE_BYTES-1:0] byte_mask
    );
        logic [MAX_LINE_BITS-1:0] bit_mask;
        for (int b = 0; b < MAX_LINE_BYTES; b++) begin
            bit_mask[8*b +: 8] = {8{byte_mask[b]}};
        end
        return bit_mask;
    endfunction

endpackage

// File: rtl/line_ram.sv
// DEPTH x LINE_BITS line store with one synchronous port; a write merges the
// enabled bytes into the addressed line and returns the merged line.
module line_ram
    import mem_pkg::*;
#(
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int IDX_BITS  = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic [IDX_BITS-1:0]    idx,
    input  logic                   we,
    input  logic [LINE_BITS/8-1:0] be,
    input  logic [LINE_BITS-1:0]   wdata,
    output logic [LINE_BITS-1:0]   rdata
);

    logic [LINE_BITS-1:0] mem [DEPTH];
    logic [LINE_BITS-1:0] bit_mask;
    logic [LINE_BITS-1:0] merged;

    assign bit_mask = LINE_BITS'(expand_mask(MAX_LINE_BYTES'(be)));
    assign merged   = (mem[idx] & ~bit_mask) | (wdata & bit_mask);

    // NOTE: the array has no reset branch on purpose; its contents must survive
    // rst_i, and a reset loop over DEPTH entries would also block RAM inference.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[idx] <= merged;
            rdata    <= merged;
        end else begin
            rdata    <= mem[idx];
        end
    end

endmodule

// File: rtl/timed_line_memory.sv
// Line-granular main-memory model: accepts one request at a time, commits it
// a fixed LATENCY cycles after accept and answers with a one-cycle ack pulse.
module timed_line_memory
    import mem_pkg::*;
#(
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int ADDR_BITS = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   write_i,
    input  logic [ADDR_BITS-1:0]   addr_i,
    input  logic [LINE_BITS-1:0]   data_i,
    input  logic [LINE_BITS/8-1:0] mask_i,
    output logic                   ack_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic [LINE_BITS-1:0]   data_o
);

    localparam int LINE_BYTES = LINE_BITS / 8;
    localparam int OFFS       = $clog2(LINE_BYTES);
    localparam int IDX_BITS   = $clog2(DEPTH);
    localparam int CNT_BITS   = $clog2(LATENCY + 1);

    if (LINE_BITS % 8 != 0 || (LINE_BITS & (LINE_BITS - 1)) != 0 || LINE_BITS > MAX_LINE_BITS
        || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 2
        || ADDR_BITS <= IDX_BITS || ADDR_BITS <= OFFS) begin : g_param_check
        $error("timed_line_memory: illegal parameter combination");
    end

    state_t                state;
    logic [CNT_BITS-1:0]   cnt;

    logic                  req_write;
    logic                  req_oor;
    logic [IDX_BITS-1:0]   req_idx;
    logic [LINE_BITS-1:0]  req_data;
    logic [LINE_BYTES-1:0] req_mask;

    logic [ADDR_BITS-1:0]  line_addr;
    logic                  accept;
    logic                  commit;
    logic                  ram_we;
    logic [LINE_BITS-1:0]  ram_rdata;
    logic [LINE_BITS-1:0]  bit_mask;
    logic [LINE_BITS-1:0]  merged_line;

    assign line_addr = addr_i >> OFFS;
    assign accept    = enable_i && (state == ST_IDLE || state == ST_RESP);
    assign commit    = (state == ST_WAIT) && (cnt == CNT_BITS'(LATENCY));
    assign ram_we    = commit && req_write && !req_oor;

    // The RAM re-reads req_idx every WAIT cycle, so at the commit edge ram_rdata
    // already holds the pre-write line; LATENCY >= 2 guarantees that read used
    // the freshly latched index.
    assign bit_mask    = LINE_BITS'(expand_mask(MAX_LINE_BYTES'(req_mask)));
    assign merged_line = req_write ? ((ram_rdata & ~bit_mask) | (req_data & bit_mask))
                                   : ram_rdata;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_write <= 1'b0;
            req_oor   <= 1'b0;
            req_idx   <= '0;
        end else if (accept) begin
            req_write <= write_i;
            req_oor   <= line_addr >= ADDR_BITS'(DEPTH);
            req_idx   <= line_addr[IDX_BITS-1:0];
        end
    end

    // Payload is only consumed after a fresh accept, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            req_data <= data_i;
            req_mask <= mask_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
            busy_o <= 1'b0;
            data_o <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_WAIT;
                        cnt    <= CNT_BITS'(1);
                        busy_o <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (commit) begin
                        state  <= ST_RESP;
                        cnt    <= '0;
                        ack_o  <= 1'b1;
                        err_o  <= req_oor;
                        data_o <= req_oor ? '0 : merged_line;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (accept) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_BITS'(1);
                    end else begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    line_ram #(
        .LINE_BITS(LINE_BITS),
        .DEPTH    (DEPTH)
    ) u_ram (
        .clk_i(clk_i),
        .idx  (req_idx),
        .we   (ram_we),
        .be   (req_mask),
        .wdata(req_data),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_timed_line_memory.sv
// Randomised bench for timed_line_memory: a default instance checked against a
// byte-level line model, plus a narrow/fast instance for the parameter sweep.
module tb_timed_line_memory;

    typedef logic [255:0] line_t;
    typedef logic [31:0]  mask_t;
    typedef logic [127:0] pline_t;
    typedef logic [15:0]  pmask_t;

    typedef struct {
        line_t data;
        logic  err;
        int    lat;
        int    busy_cnt;
        logic  ack_next;
        logic  busy_next;
    } resp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        write_i = 1'b0;
    logic [31:0] addr_i = '0;
    line_t       data_i = '0;
    mask_t       mask_i = '0;
    logic        ack_o, err_o, busy_o;
    line_t       data_o;

    logic        p_enable = 1'b0;
    logic        p_write = 1'b0;
    logic [31:0] p_addr = '0;
    pline_t      p_data = '0;
    pmask_t      p_mask = '0;
    logic        p_ack, p_err, p_busy;
    pline_t      p_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    line_t  ref_mem [int unsigned];
    pline_t p_ref   [int unsigned];

    always #5 clk_i = ~clk_i;

    timed_line_memory #(.LINE_BITS(256), .DEPTH(512), .LATENCY(10), .ADDR_BITS(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
        .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i),
        .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o), .data_o(data_o)
    );

    timed_line_memory #(.LINE_BITS(128), .DEPTH(64), .LATENCY(2), .ADDR_BITS(32)) dut_p (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(p_enable), .write_i(p_write),
        .addr_i(p_addr), .data_i(p_data), .mask_i(p_mask),
        .ack_o(p_ack), .err_o(p_err), .busy_o(p_busy), .data_o(p_rdata)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = $urandom;
        return l;
    endfunction

    // Reference: 32-byte lines, 512 of them, byte-enabled writes, read-back of the line.
    function automatic void model_access(input logic wr, input logic [31:0] addr, input line_t data,
                                         input mask_t mask, output line_t exp, output logic exp_err);
        int unsigned idx;
        idx = addr / 32;
        if (idx >= 512) begin
            exp = '0;
            exp_err = 1'b1;
            return;
        end
        exp_err = 1'b0;
        if (wr) begin
            if (!ref_mem.exists(idx)) ref_mem[idx] = '0;
            for (int b = 0; b < 32; b++) if (mask[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        exp = ref_mem[idx];
    endfunction

    function automatic void p_model(input logic wr, input logic [31:0] addr, input pline_t data,
                                    input pmask_t mask, output pline_t exp, output logic exp_err);
        int unsigned idx;
        idx = addr / 16;
        if (idx >= 64) begin
            exp = '0;
            exp_err = 1'b1;
            return;
        end
        exp_err = 1'b0;
        if (wr) begin
            if (!p_ref.exists(idx)) p_ref[idx] = '0;
            for (int b = 0; b < 16; b++) if (mask[b]) p_ref[idx][8*b +: 8] = data[8*b +: 8];
        end
        exp = p_ref[idx];
    endfunction

    // One request with enable for a single edge; optional enable/input noise while waiting.
    task automatic run_req(input logic wr, input logic [31:0] addr, input line_t data,
                           input mask_t mask, input bit noise, output resp_t r);
        enable_i = 1'b1; write_i = wr; addr_i = addr; data_i = data; mask_i = mask;
        step();
        r.busy_cnt = busy_o ? 1 : 0;
        r.lat = -1; r.data = '0; r.err = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            enable_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            write_i  = 1'($urandom_range(0, 1));
            addr_i   = $urandom;
            data_i   = rand_line();
            mask_i   = $urandom;
            step();
            if (busy_o) r.busy_cnt++;
            if (ack_o) begin
                r.lat = c; r.data = data_o; r.err = err_o;
                break;
            end
        end
        enable_i = 1'b0;
        step();
        r.ack_next  = ack_o;
        r.busy_next = busy_o;
    endtask

    task automatic run_req_p(input logic wr, input logic [31:0] addr, input pline_t data,
                             input pmask_t mask, output pline_t rd, output logic er, output int lat);
        p_enable = 1'b1; p_write = wr; p_addr = addr; p_data = data; p_mask = mask;
        step();
        lat = -1; rd = '0; er = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            p_enable = 1'b0; p_addr = $urandom; p_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (p_ack) begin
                lat = c; rd = p_rdata; er = p_err;
                break;
            end
        end
        p_enable = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) step();
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_o); end
        rst_i = 1'b1;
    endtask

    task automatic test_read_latency();
        resp_t r; line_t exp; logic exp_err;
        model_access(1'b1, 32'h60, {32{8'hA5}}, '1, exp, exp_err);
        run_req(1'b1, 32'h60, {32{8'hA5}}, '1, 1'b0, r);
        n_checks++; if (r.data !== exp) begin n_fail++; $display("FAIL preload_line3: got %h want %h", r.data, exp); end
        model_access(1'b0, 32'h60, '0, '0, exp, exp_err);
        run_req(1'b0, 32'h60, rand_line(), '0, 1'b0, r);
        n_checks++; if (r.lat !== 10) begin n_fail++; $display("FAIL read_latency: got %0d want 10", r.lat); end
        n_checks++; if (r.data !== exp) begin n_fail++; $display("FAIL read_data: got %h want %h", r.data, exp); end
        n_checks++; if (r.err !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b want 0", r.err); end
        n_checks++; if (r.busy_cnt !== 11) begin n_fail++; $display("FAIL read_busy_cycles: got %0d want 11", r.busy_cnt); end
        n_checks++; if (r.ack_next !== 1'b0) begin n_fail++; $display("FAIL read_ack_width: ack still %b", r.ack_next); end
        n_checks++; if (r.busy_next !== 1'b0) begin n_fail++; $display("FAIL read_busy_drop: got %b want 0", r.busy_next); end
        n_checks++; if (data_o !== exp) begin n_fail++; $display("FAIL read_data_hold: got %h want %h", data_o, exp); end
    endtask

    task automatic test_masked_write();
        resp_t r; line_t exp; logic exp_err;
        model_access(1'b1, 32'hA0, {32{8'h11}}, '1, exp, exp_err);
        run_req(1'b1, 32'hA0, {32{8'h11}}, '1, 1'b0, r);
        n_checks++; if (r.data !== exp) begin n_fail++; $display("FAIL preload_line5: got %h want %h", r.data, exp); end
        model_access(1'b1, 32'hA0, {32{8'hFF}}, 32'h0000_000F, exp, exp_err);
        run_req(1'b1, 32'hA0, {32{8'hFF}}, 32'h0000_000F, 1'b0, r);
        n_checks++; if (r.data !== exp) begin n_fail++; $display("FAIL masked_readback: got %h want %h", r.data, exp); end
        n_checks++; if (r.lat !== 10) begin n_fail++; $display("FAIL masked_latency: got %0d want 10", r.lat); end
        model_access(1'b0, 32'hBF, '0, '0, exp, exp_err);
        run_req(1'b0, 32'hBF, rand_line(), $urandom, 1'b1, r);
        n_checks++; if (r.data !== exp) begin n_fail++; $display("FAIL masked_reread: got %h want %h", r.data, exp); end
        n_checks++; if (r.lat !== 10) begin n_fail++; $display("FAIL noisy_latency: got %0d want 10", r.lat); end
        n_checks++; if (r.ack_next !== 1'b0) begin n_fail++; $display("FAIL noisy_extra_ack: got %b want 0", r.ack_next); end
        model_access(1'b1, 32'hA0, rand_line(), '0, exp, exp_err);
        run_req(1'b1, 32'hA0, rand_line(), '0, 1'b0, r);
        n_checks++; if (r.data !== exp || r.lat !== 10) begin
            n_fail++; $display("FAIL zero_mask_write: got %h lat %0d want %h lat 10", r.data, r.lat, exp);
        end
    endtask

    task automatic test_out_of_range();
        resp_t r; line_t exp; logic exp_err; line_t d;
        d = rand_line();
        model_access(1'b1, 32'h0, d, '1, exp, exp_err);
        run_req(1'b1, 32'h0, d, '1, 1'b0, r);
        n_checks++; if (r.data !== exp) begin n_fail++; $display("FAIL preload_line0: got %h want %h", r.data, exp); end
        model_access(1'b1, 32'h4000, rand_line(), '1, exp, exp_err);
        run_req(1'b1, 32'h4000, rand_line(), '1, 1'b0, r);
        n_checks++; if (r.err !== exp_err) begin n_fail++; $display("FAIL oor_err: got %b want %b", r.err, exp_err); end
        n_checks++; if (r.data !== exp) begin n_fail++; $display("FAIL oor_data: got %h want %h", r.data, exp); end
        n_checks++; if (r.lat !== 10) begin n_fail++; $display("FAIL oor_latency: got %0d want 10", r.lat); end
        model_access(1'b0, 32'h0, '0, '0, exp, exp_err);
        run_req(1'b0, 32'h0, '0, '0, 1'b0, r);
        n_checks++; if (r.data !== exp || r.err !== 1'b0) begin
            n_fail++; $display("FAIL oor_no_wrap: got %h err %b want %h err 0", r.data, r.err, exp);
        end
    endtask

    task automatic test_back_to_back();
        resp_t r; line_t exp_w, exp_r, wd; logic exp_err; mask_t m;
        int ack_cyc[$]; line_t ack_dat[$]; logic ack_err[$]; logic busy_gap;
        wd = rand_line();
        m  = $urandom | 32'h1;
        model_access(1'b1, 32'hE0, rand_line(), '1, exp_w, exp_err);
        run_req(1'b1, 32'hE0, exp_w, '1, 1'b0, r);
        n_checks++; if (r.data !== exp_w) begin n_fail++; $display("FAIL preload_line7: got %h want %h", r.data, exp_w); end
        model_access(1'b1, 32'hE4, wd, m, exp_w, exp_err);
        model_access(1'b0, 32'hEC, '0, '0, exp_r, exp_err);
        busy_gap = 1'b0;
        enable_i = 1'b1; write_i = 1'b1; addr_i = 32'hE4; data_i = wd; mask_i = m;
        step();
        for (int c = 1; c <= 40; c++) begin
            step();
            if (ack_cyc.size() < 2 && !busy_o) busy_gap = 1'b1;
            if (ack_o) begin
                ack_cyc.push_back(c); ack_dat.push_back(data_o); ack_err.push_back(err_o);
                if (ack_cyc.size() == 1) begin
                    write_i = 1'b0; addr_i = 32'hEC; data_i = rand_line(); mask_i = $urandom;
                end else begin
                    enable_i = 1'b0;
                end
            end
        end
        enable_i = 1'b0;
        n_checks++; if (ack_cyc.size() !== 2) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 2", ack_cyc.size()); end
        n_checks++; if (busy_gap !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_gap: busy dropped between requests"); end
        if (ack_cyc.size() >= 2) begin
            n_checks++; if (ack_cyc[0] !== 10) begin n_fail++; $display("FAIL b2b_first_ack: cycle %0d want 10", ack_cyc[0]); end
            n_checks++; if (ack_cyc[1] - ack_cyc[0] !== 11) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d want 11", ack_cyc[1] - ack_cyc[0]);
            end
            n_checks++; if (ack_dat[0] !== exp_w) begin n_fail++; $display("FAIL b2b_write_data: got %h want %h", ack_dat[0], exp_w); end
            n_checks++; if (ack_dat[1] !== exp_r) begin n_fail++; $display("FAIL b2b_read_data: got %h want %h", ack_dat[1], exp_r); end
            n_checks++; if (ack_err[0] !== 1'b0 || ack_err[1] !== 1'b0) begin
                n_fail++; $display("FAIL b2b_err: got %b%b want 00", ack_err[0], ack_err[1]);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        resp_t r; line_t exp, old; logic exp_err; int acks;
        model_access(1'b1, 32'h40, rand_line(), '1, old, exp_err);
        run_req(1'b1, 32'h40, old, '1, 1'b0, r);
        n_checks++; if (r.data !== old) begin n_fail++; $display("FAIL preload_line2: got %h want %h", r.data, old); end
        enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h40; data_i = ~old; mask_i = '1;
        step();
        enable_i = 1'b0;
        repeat (4) step();
        #2 rst_i = 1'b0;
        #1;
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL midreset_ack: got %b want 0", ack_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy_o); end
        repeat (2) step();
        rst_i = 1'b1;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (ack_o) acks++;
        end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL midreset_late_ack: got %0d acks want 0", acks); end
        model_access(1'b0, 32'h40, '0, '0, exp, exp_err);
        run_req(1'b0, 32'h40, '0, '0, 1'b0, r);
        n_checks++; if (r.data !== exp) begin n_fail++; $display("FAIL midreset_line2: got %h want %h", r.data, exp); end
    endtask

    task automatic test_random();
        int unsigned pool [8] = '{1, 4, 6, 9, 100, 255, 300, 511};
        resp_t r; line_t exp, d; logic exp_err, wr; logic [31:0] addr; mask_t m;
        for (int i = 0; i < 8; i++) begin
            d = rand_line();
            model_access(1'b1, pool[i] * 32, d, '1, exp, exp_err);
            run_req(1'b1, pool[i] * 32, d, '1, 1'b0, r);
            n_checks++; if (r.data !== exp) begin n_fail++; $display("FAIL rand_preload %0d: got %h want %h", pool[i], r.data, exp); end
        end
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) addr = 32'h4000 + $urandom_range(0, 32'h0FFF_FFFF);
            else addr = pool[$urandom_range(0, 7)] * 32 + $urandom_range(0, 31);
            wr = 1'($urandom_range(0, 1));
            d  = rand_line();
            m  = $urandom;
            model_access(wr, addr, d, m, exp, exp_err);
            run_req(wr, addr, d, m, 1'($urandom_range(0, 1)), r);
            n_checks++; if (r.data !== exp || r.err !== exp_err || r.lat !== 10) begin
                n_fail++;
                $display("FAIL rand_op %0d addr %h: got %h err %b lat %0d want %h err %b lat 10",
                         i, addr, r.data, r.err, r.lat, exp, exp_err);
            end
        end
    endtask

    task automatic test_param_sweep();
        pline_t rd, exp, d; logic er, exp_err; int lat;
        d = {$urandom, $urandom, $urandom, $urandom};
        p_model(1'b1, 32'hA0, d, '1, exp, exp_err);
        run_req_p(1'b1, 32'hA0, d, '1, rd, er, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sweep_latency: got %0d want 2", lat); end
        n_checks++; if (rd !== exp || er !== 1'b0) begin n_fail++; $display("FAIL sweep_write: got %h err %b want %h", rd, er, exp); end
        n_checks++; if (p_busy !== 1'b0) begin n_fail++; $display("FAIL sweep_busy_drop: got %b want 0", p_busy); end
        p_model(1'b0, 32'hAF, '0, '0, exp, exp_err);
        run_req_p(1'b0, 32'hAF, '0, '0, rd, er, lat);
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL sweep_offs4_read: got %h want %h", rd, exp); end
        d = {$urandom, $urandom, $urandom, $urandom};
        p_model(1'b1, 32'h3F0, d, '1, exp, exp_err);
        run_req_p(1'b1, 32'h3F0, d, '1, rd, er, lat);
        n_checks++; if (rd !== exp || er !== 1'b0) begin n_fail++; $display("FAIL sweep_last_line: got %h err %b want %h", rd, er, exp); end
        p_model(1'b1, 32'h400, '1, '1, exp, exp_err);
        run_req_p(1'b1, 32'h400, '1, '1, rd, er, lat);
        n_checks++; if (er !== exp_err || rd !== exp || lat !== 2) begin
            n_fail++; $display("FAIL sweep_oor: got %h err %b lat %0d want %h err %b", rd, er, lat, exp, exp_err);
        end
        p_model(1'b0, 32'hA0, '0, '0, exp, exp_err);
        run_req_p(1'b0, 32'hA0, '0, '0, rd, er, lat);
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL sweep_no_wrap: got %h want %h", rd, exp); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_masked_write();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
